rename_latch: RTL and testbench

RENAME_LATCH -- requirements
Module: rename_latch

---
 rtl/rename_latch.sv | 159 +++++++++++++++
 tb/tb_rename_latch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_latch.sv
// rtl/rename_latch.sv - pipeline latch between instruction buffer and rename with checkpoint accounting
//
// Optional feature macro: RENAME_LATCH_PERF_CNT_EN (enables the two stall performance counters).
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   flush_i                        mispredict flush, discards latched work, restores all checkpoints
//   stall_i                        rename cannot accept a group this cycle
//   instBufferReady_i              buffer presents four valid packets
//   decodedPacket0_i..3_i          incoming dispatch group
//   branchCount_i                  branches in the incoming group (0..4)
//   ctrlResolved_i                 one checkpoint released this cycle
//   stall_o                        back-pressure to the instruction buffer
//   renameReady_o                  latched group valid
//   decodedPacket0_o..3_o          latched group
//   branchCount_o                  latched branch count
//   freeCkpt_o                     free checkpoint count
//   ckptErr_o                      sticky checkpoint over-release error
//   stallCkptCnt_o, stallDownCnt_o stall performance counters (zero when the feature is off)
module rename_latch #(
  parameter int PKT_W  = 132,
  parameter int CKPT   = 4,
  parameter int CKPT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              instBufferReady_i,
  input  logic [PKT_W-1:0]  decodedPacket0_i,
  input  logic [PKT_W-1:0]  decodedPacket1_i,
  input  logic [PKT_W-1:0]  decodedPacket2_i,
  input  logic [PKT_W-1:0]  decodedPacket3_i,
  input  logic [2:0]        branchCount_i,
  input  logic              ctrlResolved_i,
  output logic              stall_o,
  output logic              renameReady_o,
  output logic [PKT_W-1:0]  decodedPacket0_o,
  output logic [PKT_W-1:0]  decodedPacket1_o,
  output logic [PKT_W-1:0]  decodedPacket2_o,
  output logic [PKT_W-1:0]  decodedPacket3_o,
  output logic [2:0]        branchCount_o,
  output logic [CKPT_W-1:0] freeCkpt_o,
  output logic              ckptErr_o,
  output logic [31:0]       stallCkptCnt_o,
  output logic [31:0]       stallDownCnt_o
);

  localparam logic [CKPT_W-1:0] CKPT_FULL = CKPT_W'(CKPT);
  // Comparison width large enough for both the branch count and the free count.
  localparam int CMP_W = (CKPT_W > 3) ? CKPT_W : 3;

  logic [CKPT_W-1:0] free_ckpt;
  logic [CKPT_W-1:0] free_nxt;
  logic [CKPT_W-1:0] alloc;
  logic [CMP_W-1:0]  bc_ext;
  logic [CMP_W-1:0]  free_ext;
  logic              ckpt_short;
  logic              accept;
  logic              over_release;

  assign bc_ext   = CMP_W'(branchCount_i);
  assign free_ext = CMP_W'(free_ckpt);

  // A group with zero branches never compares greater than any free count,
  // so it is never blocked here even with no checkpoints left.
  assign ckpt_short = instBufferReady_i & (bc_ext > free_ext);
  assign stall_o    = stall_i | ckpt_short;
  assign accept     = instBufferReady_i & ~stall_o & ~flush_i;

  // An accepted group never exceeds the free count, so truncating to
  // CKPT_W bits cannot lose information.
  assign alloc = accept ? CKPT_W'(branchCount_i) : '0;

  // Releasing into a full pool would overflow; clamp and flag instead.
  assign over_release = ctrlResolved_i & (free_ckpt == CKPT_FULL) & (alloc == '0);

  always_comb begin
    free_nxt = free_ckpt - alloc + CKPT_W'(ctrlResolved_i);
    if (over_release) begin
      free_nxt = CKPT_FULL;
    end
    // Flush restores every checkpoint and ignores a same-cycle release.
    if (flush_i) begin
      free_nxt = CKPT_FULL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_ckpt <= CKPT_FULL;
      ckptErr_o <= 1'b0;
    end else begin
      free_ckpt <= free_nxt;
      if (over_release && !flush_i) begin
        ckptErr_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      renameReady_o <= 1'b0;
    end else if (flush_i) begin
      renameReady_o <= 1'b0;
    end else if (accept) begin
      renameReady_o <= 1'b1;
    end else if (!stall_i) begin
      renameReady_o <= 1'b0;
    end
  end

  // Payload only moves on accept; otherwise it holds (stale data is
  // harmless once renameReady_o is low).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decodedPacket0_o <= '0;
      decodedPacket1_o <= '0;
      decodedPacket2_o <= '0;
      decodedPacket3_o <= '0;
      branchCount_o    <= '0;
    end else if (accept) begin
      decodedPacket0_o <= decodedPacket0_i;
      decodedPacket1_o <= decodedPacket1_i;
      decodedPacket2_o <= decodedPacket2_i;
      decodedPacket3_o <= decodedPacket3_i;
      branchCount_o    <= branchCount_i;
    end
  end

  assign freeCkpt_o = free_ckpt;

`ifdef RENAME_LATCH_PERF_CNT_EN
  logic [31:0] stall_ckpt_cnt;
  logic [31:0] stall_down_cnt;

  // Counters survive flush; only reset clears them. Both wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_ckpt_cnt <= '0;
      stall_down_cnt <= '0;
    end else begin
      if (ckpt_short && !stall_i) begin
        stall_ckpt_cnt <= stall_ckpt_cnt + 32'd1;
      end
      if (stall_i && instBufferReady_i) begin
        stall_down_cnt <= stall_down_cnt + 32'd1;
      end
    end
  end

  assign stallCkptCnt_o = stall_ckpt_cnt;
  assign stallDownCnt_o = stall_down_cnt;
`else
  assign stallCkptCnt_o = 32'd0;
  assign stallDownCnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_rename_latch.sv
// tb/tb_rename_latch.sv - scoreboard bench for rename_latch
module tb_rename_latch;

  localparam int PKT_W = 132;
`ifdef RENAME_LATCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             stall_in;
  logic             buf_ready;
  logic [PKT_W-1:0] pkt_in [4];
  logic [2:0]       bc_in;
  logic             resolved;
  logic             stall_out;
  logic             ren_ready;
  logic [PKT_W-1:0] pkt_out [4];
  logic [2:0]       bc_out;
  logic [2:0]       free_ckpt;
  logic             ckpt_err;
  logic [31:0]      ckpt_cnt;
  logic [31:0]      down_cnt;

  rename_latch #(.PKT_W(PKT_W), .CKPT(4), .CKPT_W(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush),
    .stall_i           (stall_in),
    .instBufferReady_i (buf_ready),
    .decodedPacket0_i  (pkt_in[0]),
    .decodedPacket1_i  (pkt_in[1]),
    .decodedPacket2_i  (pkt_in[2]),
    .decodedPacket3_i  (pkt_in[3]),
    .branchCount_i     (bc_in),
    .ctrlResolved_i    (resolved),
    .stall_o           (stall_out),
    .renameReady_o     (ren_ready),
    .decodedPacket0_o  (pkt_out[0]),
    .decodedPacket1_o  (pkt_out[1]),
    .decodedPacket2_o  (pkt_out[2]),
    .decodedPacket3_o  (pkt_out[3]),
    .branchCount_o     (bc_out),
    .freeCkpt_o        (free_ckpt),
    .ckptErr_o         (ckpt_err),
    .stallCkptCnt_o    (ckpt_cnt),
    .stallDownCnt_o    (down_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       stall;
    logic       rdy;
    logic [2:0] free;
    logic       err;
    int         seed;
    logic [2:0] bc;
    logic       chk_cnt;
    int         c;
    int         d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec    = 0;

  // Packet k of group s; seed 0 stands for the all-zero reset contents.
  function automatic logic [PKT_W-1:0] mk(input int s, input int k);
    logic [PKT_W-1:0] v;
    v = '0;
    if (s != 0) begin
      v[31:0]    = 32'(s * 16 + k);
      v[131:100] = ~32'(s + k * 7);
      v[67:64]   = 4'(k + 1);
    end
    return v;
  endfunction

  task automatic chk(input int idx, input string name, input logic [PKT_W-1:0] act,
                     input logic [PKT_W-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, want);
    end
  endtask

  // Monitor: pops one expected record per falling edge while work is queued.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.idx, "stall_o", PKT_W'(stall_out), PKT_W'(e.stall));
      chk(e.idx, "renameReady_o", PKT_W'(ren_ready), PKT_W'(e.rdy));
      chk(e.idx, "freeCkpt_o", PKT_W'(free_ckpt), PKT_W'(e.free));
      chk(e.idx, "ckptErr_o", PKT_W'(ckpt_err), PKT_W'(e.err));
      chk(e.idx, "branchCount_o", PKT_W'(bc_out), PKT_W'(e.bc));
      for (int k = 0; k < 4; k++) begin
        chk(e.idx, $sformatf("decodedPacket%0d_o", k), pkt_out[k], mk(e.seed, k));
      end
      if (e.chk_cnt) begin
        chk(e.idx, "stallCkptCnt_o", PKT_W'(ckpt_cnt), PERF ? PKT_W'(e.c) : '0);
        chk(e.idx, "stallDownCnt_o", PKT_W'(down_cnt), PERF ? PKT_W'(e.d) : '0);
      end
    end
  end

  // Drive one cycle of inputs (shortly after the rising edge) and queue the
  // values expected at the following falling edge: stall_o reflects these
  // inputs, registered outputs reflect the previous cycle's inputs.
  task automatic step(input logic r_rst, input logic r_rdy, input logic r_st, input logic r_fl,
                      input logic [2:0] r_bc, input logic r_res, input int r_seed,
                      input logic e_stall, input logic e_rdy, input logic [2:0] e_free,
                      input logic e_err, input int e_seed, input logic [2:0] e_bc,
                      input logic e_cc, input int e_c, input int e_d);
    exp_t e;
    @(posedge clk);
    #2;
    reset     = r_rst;
    buf_ready = r_rdy;
    stall_in  = r_st;
    flush     = r_fl;
    bc_in     = r_bc;
    resolved  = r_res;
    for (int k = 0; k < 4; k++) pkt_in[k] = mk(r_seed, k);
    e.idx = vec; e.stall = e_stall; e.rdy = e_rdy; e.free = e_free; e.err = e_err;
    e.seed = e_seed; e.bc = e_bc; e.chk_cnt = e_cc; e.c = e_c; e.d = e_d;
    exp_q.push_back(e);
    vec++;
  endtask

  initial begin
    reset = 1'b1; buf_ready = 1'b0; stall_in = 1'b0; flush = 1'b0;
    bc_in = '0; resolved = 1'b0;
    for (int k = 0; k < 4; k++) pkt_in[k] = '0;

    //   rst rdy st fl bc res seed | stall rdy free err seed bc cc c d
    step(1, 0, 0, 0, 0, 0, 0,      0, 0, 4, 0, 0, 0, 1, 0, 0); // reset state
    // four single-branch groups drain the pool, fifth stalls
    step(0, 1, 0, 0, 1, 0, 1,      0, 0, 4, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 2,      0, 1, 3, 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 3,      0, 1, 2, 0, 2, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 4,      0, 1, 1, 0, 3, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 5,      1, 1, 0, 0, 4, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 5,      1, 0, 0, 0, 4, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 5,      1, 0, 0, 0, 4, 1, 0, 0, 0); // release one
    step(0, 1, 0, 0, 1, 0, 5,      0, 0, 1, 0, 4, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0,      0, 1, 0, 0, 5, 1, 0, 0, 0);
    // flush restores the pool
    step(0, 0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 6,      0, 0, 4, 0, 5, 1, 0, 0, 0);
    // three stalled cycles hold the latched group
    step(0, 1, 1, 0, 0, 0, 7,      1, 1, 4, 0, 6, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 7,      1, 1, 4, 0, 6, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 7,      1, 1, 4, 0, 6, 0, 0, 0, 0);
    step(0, 1, 0, 0, 2, 0, 7,      0, 1, 4, 0, 6, 0, 0, 0, 0);
    // free=2: allocate two and release one in the same cycle
    step(0, 1, 0, 0, 2, 1, 8,      0, 1, 2, 0, 7, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0,      0, 1, 1, 0, 8, 2, 0, 0, 0);
    // release up to full, then one over-release
    step(0, 0, 0, 0, 0, 1, 0,      0, 0, 1, 0, 8, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,      0, 0, 2, 0, 8, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,      0, 0, 3, 0, 8, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,      0, 0, 4, 0, 8, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0,      0, 0, 4, 1, 8, 2, 0, 0, 0); // flush keeps err
    step(0, 0, 0, 0, 0, 0, 0,      0, 0, 4, 1, 8, 2, 0, 0, 0);
    // latch a group, stall it, then reset mid-cycle
    step(0, 1, 0, 0, 0, 0, 9,      0, 0, 4, 1, 8, 2, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 10,     1, 1, 4, 1, 9, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0,      0, 0, 4, 0, 0, 0, 1, 0, 0); // async clear
    // drain the pool then hold a two-branch group for five cycles
    step(0, 1, 0, 0, 2, 0, 11,     0, 0, 4, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 2, 0, 12,     0, 1, 2, 0, 11, 2, 1, 0, 0);
    step(0, 1, 0, 0, 2, 0, 13,     1, 1, 0, 0, 12, 2, 1, 0, 0);
    step(0, 1, 0, 0, 2, 0, 13,     1, 0, 0, 0, 12, 2, 1, 1, 0);
    step(0, 1, 0, 0, 2, 0, 13,     1, 0, 0, 0, 12, 2, 1, 2, 0);
    step(0, 1, 0, 0, 2, 0, 13,     1, 0, 0, 0, 12, 2, 1, 3, 0);
    step(0, 1, 0, 0, 2, 0, 13,     1, 0, 0, 0, 12, 2, 1, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 12, 2, 1, 5, 0);
    // downstream stall with a ready buffer
    step(0, 1, 1, 0, 0, 0, 14,     1, 0, 0, 0, 12, 2, 1, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 12, 2, 1, 5, 1);
    // zero-branch group passes with no free checkpoints
    step(0, 1, 0, 0, 0, 0, 15,     0, 0, 0, 0, 12, 2, 1, 5, 1);
    step(0, 0, 0, 0, 0, 0, 0,      0, 1, 0, 0, 15, 0, 1, 5, 1);

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d records left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
